multicycle_control: RTL

Main control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU control decoder and drives its 2-bit AluOp, plus every datapath strobe and mux select.
- One state per instruction phase.
- Outputs are Moore-decoded from the state register.
- Supported instructions: R-type, lw, sw, beq, j, addi.

---
 rtl/multicycle_control.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM for the multicycle MIPS datapath. There is one state per
//   instruction phase, and every datapath strobe and select is Moore-decoded
//   from the state register. AluOp feeds the downstream ALU control decoder.
//   Supported instructions: R-type, lw, sw, beq, j, addi.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   opcode       instruction[31:26]; sampled only in DECODE
//   PCWrite      unconditional PC load
//   PCWriteCond  PC load qualified by ALU zero (beq)
//   IorD         memory address select: 0 = PC, 1 = ALUOut
//   MemRead      memory read strobe
//   MemWrite     memory write strobe
//   IRWrite      instruction register load
//   MemtoReg     register write-data select: 0 = ALUOut, 1 = MDR
//   RegDst       destination select: 0 = rt, 1 = rd
//   RegWrite     register file write
//   AluSrcA      ALU A select: 0 = PC, 1 = rs
//   AluSrcB      ALU B select: 00 rt, 01 +4, 10 imm, 11 imm<<2
//   AluOp        00 add, 01 sub, 10 decode funct
//   PCSource     00 ALU result, 01 ALUOut, 10 jump target
//   state        current state (debug)
//   retire       pulse in the final state of each completed instruction
//   illegal_op   pulse in the FETCH after an unsupported opcode
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               AluSrcA,
    output logic [1:0]         AluSrcB,
    output logic [1:0]         AluOp,
    output logic [1:0]         PCSource,
    output logic [STATE_W-1:0] state,
    output logic               retire,
    output logic               illegal_op
);

    typedef enum logic [STATE_W-1:0] {
        FETCH     = 'd0,
        DECODE    = 'd1,
        MEM_ADDR  = 'd2,
        MEM_READ  = 'd3,
        MEM_WB    = 'd4,
        MEM_WRITE = 'd5,
        R_EXEC    = 'd6,
        R_WB      = 'd7,
        BRANCH    = 'd8,
        JUMP      = 'd9,
        ADDI_EXEC = 'd10,
        ADDI_WB   = 'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
    } ctrl_t;

    state_t state_q, state_d;
    logic   is_store_q, is_store_d;
    logic   illegal_q, illegal_d;
    ctrl_t  ctrl;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            is_store_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            illegal_q  <= illegal_d;
        end
    end

    // NOTE: every signal driven here gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = FETCH;
        is_store_d = is_store_q;
        ctrl       = '0;

        case (state_q)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.pc_write  = 1'b1;
                state_d        = DECODE;
            end
            DECODE: begin
                ctrl.alu_src_b = 2'b11;
                // lw/sw share MEM_ADDR; remember which one now, because the
                // opcode is not trusted outside DECODE.
                is_store_d     = (opcode == OP_SW);
                case (opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = R_EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EXEC;
                    default:      state_d = FETCH;
                endcase
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                state_d        = is_store_q ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
                state_d       = MEM_WB;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
                ctrl.retire    = 1'b1;
            end
            R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = 2'b10;
                state_d        = R_WB;
            end
            R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.retire    = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
                ctrl.retire        = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b10;
                ctrl.retire    = 1'b1;
            end
            ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                state_d        = ADDI_WB;
            end
            ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            default: begin
                // Unused codes 12-15: all outputs stay 0, recover to FETCH.
                state_d = FETCH;
            end
        endcase
    end

    // Only DECODE can fall back to FETCH early; that is an unsupported opcode.
    assign illegal_d = (state_q == DECODE) && (state_d == FETCH);

    // NOTE: outputs are gated by reset combinationally so no write strobe
    // survives even the remainder of the cycle in which reset rises.
    assign {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, PCSource, retire}
        = reset ? '0 : ctrl;

    assign state      = state_q;
    assign illegal_op = illegal_q;

endmodule
